// File: rtl/jtag_host_pkg.sv
// Shared types and defaults for the JTAG host: FSM state encoding, vector sizing
// and the TCK divider terminal count.
package jtag_host_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      DONE
   } jtagStateT;

   localparam int MAX_LEN_DEFAULT = 32;
   localparam int LEN_W_DEFAULT   = 6;

   // Last divider count of a TCK half-period; the divider runs 0..clkDiv-1.
   function automatic int divTermCount(input int clkDiv);
      return clkDiv - 1;
   endfunction

endpackage

// File: rtl/jtag_host_synch.sv
// Two-flop synchronizer for the asynchronous TDO line from the target,
// with a synchronous active-high clear.
module jtag_host_synch (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync
);

   logic [1:0] syncReg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         syncReg <= '0;
      end else begin
         syncReg <= {syncReg[0], i_async};
      end
   end

   assign o_sync = syncReg[1];

endmodule

// File: rtl/jtag_host.sv
// JTAG initiator: turns one {len, TMS, TDI} command into a divided TCK burst
// and returns the TDO bits captured at the end of each TCK high phase.
module jtag_host
   import jtag_host_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int MAX_LEN = MAX_LEN_DEFAULT,
   parameter int LEN_W   = LEN_W_DEFAULT
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_cmdValid,
   output logic               o_cmdReady,
   input  logic [LEN_W-1:0]   i_cmdLen,
   input  logic [MAX_LEN-1:0] i_cmdTms,
   input  logic [MAX_LEN-1:0] i_cmdTdi,
   output logic               o_rspValid,
   output logic [MAX_LEN-1:0] o_rspTdo,
   output logic               o_TCK,
   output logic               o_TMS,
   output logic               o_TDI,
   input  logic               i_TDO
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(divTermCount(CLK_DIV));
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   jtagStateT          stateReg, stateNext;
   logic [DIV_W-1:0]   divCntReg, divCntNext;
   logic [LEN_W-1:0]   bitIdxReg, bitIdxNext;
   logic [LEN_W-1:0]   lenReg, lenNext;
   logic [MAX_LEN-1:0] tmsShReg, tmsShNext;
   logic [MAX_LEN-1:0] tdiShReg, tdiShNext;
   logic [MAX_LEN-1:0] tdoReg, tdoNext;
   logic [MAX_LEN-1:0] rspTdoReg, rspTdoNext;
   logic               tckReg, tckNext;
   logic               tmsReg, tmsNext;
   logic               tdiReg, tdiNext;
   logic               rspValidReg, rspValidNext;

   logic               tdoS;
   logic               accept;
   logic               capture;
   logic               lastBit;
   logic [LEN_W-1:0]   lenSat;

   jtag_host_synch uTdoSynch (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_async (i_TDO),
      .o_sync  (tdoS)
   );

   assign lenSat  = (i_cmdLen > LEN_MAX) ? LEN_MAX : i_cmdLen;
   assign lastBit = (bitIdxReg == (lenReg - LEN_W'(1)));

   always_comb begin
      stateNext  = stateReg;
      divCntNext = divCntReg;
      bitIdxNext = bitIdxReg;
      lenNext    = lenReg;
      tmsShNext  = tmsShReg;
      tdiShNext  = tdiShReg;
      accept     = 1'b0;
      capture    = 1'b0;
      case (stateReg)
         IDLE: begin
            if (i_cmdValid) begin
               accept     = 1'b1;
               lenNext    = lenSat;
               tmsShNext  = i_cmdTms;
               tdiShNext  = i_cmdTdi;
               bitIdxNext = '0;
               divCntNext = '0;
               stateNext  = (lenSat == '0) ? DONE : LOW;
            end
         end
         LOW: begin
            if (divCntReg == DIV_TC) begin
               divCntNext = '0;
               stateNext  = HIGH;
            end else begin
               divCntNext = divCntReg + 1'b1;
            end
         end
         HIGH: begin
            if (divCntReg == DIV_TC) begin
               divCntNext = '0;
               capture    = 1'b1;
               if (lastBit) begin
                  stateNext = DONE;
               end else begin
                  // Shift so the next bit to drive is always at index 0.
                  bitIdxNext = bitIdxReg + 1'b1;
                  tmsShNext  = tmsShReg >> 1;
                  tdiShNext  = tdiShReg >> 1;
                  stateNext  = LOW;
               end
            end else begin
               divCntNext = divCntReg + 1'b1;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Pin outputs are registered from the next state so they change cleanly on
   // the clock edge that enters each phase; TMS/TDI only move on LOW entry.
   always_comb begin
      tckNext      = (stateNext == HIGH);
      rspValidNext = (stateNext == DONE);
      tmsNext      = tmsReg;
      tdiNext      = tdiReg;
      if (stateNext == LOW) begin
         tmsNext = tmsShNext[0];
         tdiNext = tdiShNext[0];
      end
   end

   // Capture vector clears on accept, so bits at index len and above stay 0.
   for (genvar gi = 0; gi < MAX_LEN; gi++) begin : gTdoBit
      assign tdoNext[gi] = accept ? 1'b0 :
                           (capture && (bitIdxReg == LEN_W'(gi))) ? tdoS :
                           tdoReg[gi];
   end

   assign rspTdoNext = (stateNext == DONE) ? tdoNext : rspTdoReg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stateReg    <= IDLE;
         divCntReg   <= '0;
         bitIdxReg   <= '0;
         lenReg      <= '0;
         tmsShReg    <= '0;
         tdiShReg    <= '0;
         tdoReg      <= '0;
         rspTdoReg   <= '0;
         tckReg      <= 1'b0;
         tmsReg      <= 1'b1;
         tdiReg      <= 1'b0;
         rspValidReg <= 1'b0;
      end else begin
         stateReg    <= stateNext;
         divCntReg   <= divCntNext;
         bitIdxReg   <= bitIdxNext;
         lenReg      <= lenNext;
         tmsShReg    <= tmsShNext;
         tdiShReg    <= tdiShNext;
         tdoReg      <= tdoNext;
         rspTdoReg   <= rspTdoNext;
         tckReg      <= tckNext;
         tmsReg      <= tmsNext;
         tdiReg      <= tdiNext;
         rspValidReg <= rspValidNext;
      end
   end

   assign o_cmdReady = (stateReg == IDLE);
   assign o_rspValid = rspValidReg;
   assign o_rspTdo   = rspTdoReg;
   assign o_TCK      = tckReg;
   assign o_TMS      = tmsReg;
   assign o_TDI      = tdiReg;

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: table of commands with hand-derived responses, a
// scoreboard queue checked on each response, and a one-stage TDI->TDO target model.
module tb_jtag_host;

   localparam int CLK_DIV = 4;
   localparam int MAX_LEN = 32;
   localparam int LEN_W   = 6;

   logic               i_clk = 1'b0;
   logic               i_rst = 1'b1;
   logic               i_cmdValid = 1'b0;
   logic               o_cmdReady;
   logic [LEN_W-1:0]   i_cmdLen = '0;
   logic [MAX_LEN-1:0] i_cmdTms = '0;
   logic [MAX_LEN-1:0] i_cmdTdi = '0;
   logic               o_rspValid;
   logic [MAX_LEN-1:0] o_rspTdo;
   logic               o_TCK;
   logic               o_TMS;
   logic               o_TDI;
   logic               i_TDO;

   jtag_host #(
      .CLK_DIV (CLK_DIV),
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_cmdValid (i_cmdValid),
      .o_cmdReady (o_cmdReady),
      .i_cmdLen   (i_cmdLen),
      .i_cmdTms   (i_cmdTms),
      .i_cmdTdi   (i_cmdTdi),
      .o_rspValid (o_rspValid),
      .o_rspTdo   (o_rspTdo),
      .o_TCK      (o_TCK),
      .o_TMS      (o_TMS),
      .o_TDI      (o_TDI),
      .i_TDO      (i_TDO)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Target model: on each TCK rise it presents the TDI it took at the previous rise.
   logic tdoForce = 1'b1;
   logic tdoModel = 1'b0;
   logic prevTdi  = 1'b0;
   logic modelClr = 1'b0;
   int   riseCnt  = 0;
   logic tmsAtRise [1024];

   assign i_TDO = tdoForce ? 1'b1 : tdoModel;

   always @(posedge o_TCK or posedge modelClr) begin
      if (modelClr) begin
         prevTdi  = 1'b0;
         tdoModel = 1'b0;
      end else begin
         tdoModel = prevTdi;
         prevTdi  = o_TDI;
         tmsAtRise[riseCnt % 1024] = o_TMS;
         riseCnt++;
      end
   end

   typedef struct {
      logic [LEN_W-1:0]   len;
      logic [MAX_LEN-1:0] tms;
      logic [MAX_LEN-1:0] tdi;
      logic [MAX_LEN-1:0] expTdo;
      int                 expLat;
      int                 expRises;
   } cmdVecT;

   typedef struct {
      logic [MAX_LEN-1:0] expTdo;
      int                 expLat;
      int                 expRises;
      int                 accCyc;
      int                 riseBase;
   } sbEntryT;

   sbEntryT sbQ[$];
   int      rspCycHist[$];
   int      rspSeen = 0;
   int      total = 0;
   int      bad = 0;
   sbEntryT monE;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge i_clk) begin
      if (!i_rst && o_rspValid === 1'b1) begin
         rspSeen++;
         rspCycHist.push_back(cyc);
         if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got rspValid=1 tdo=0x%0h, want no response (cycle %0d)",
                     o_rspTdo, cyc);
         end else begin
            monE = sbQ.pop_front();
            $display("rsp: tdo=0x%08h lat=%0d rises=%0d", o_rspTdo, cyc - monE.accCyc,
                     riseCnt - monE.riseBase);
            check("rsp_tdo", o_rspTdo, monE.expTdo);
            check("rsp_latency", cyc - monE.accCyc, monE.expLat);
            check("rsp_tck_rises", riseCnt - monE.riseBase, monE.expRises);
         end
      end
   end

   task automatic pulseModelClr();
      modelClr = 1'b1;
      #1;
      modelClr = 1'b0;
   endtask

   // Called at a falling edge; holds valid until the DUT is ready, then scores it.
   task automatic sendCmd(input cmdVecT v, output int accCyc, output int base);
      int waited;
      sbEntryT e;
      waited     = 0;
      accCyc     = -1;
      base       = riseCnt;
      i_cmdValid = 1'b1;
      i_cmdLen   = v.len;
      i_cmdTms   = v.tms;
      i_cmdTdi   = v.tdi;
      while (o_cmdReady !== 1'b1 && waited < 3000) begin
         @(negedge i_clk);
         waited++;
      end
      if (o_cmdReady !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got cmdReady=%b, want 1 within 3000 cycles", o_cmdReady);
         i_cmdValid = 1'b0;
      end else begin
         accCyc = cyc;
         base   = riseCnt;
         e = '{v.expTdo, v.expLat, v.expRises, accCyc, base};
         sbQ.push_back(e);
         $display("cmd: len=%0d tms=0x%08h tdi=0x%08h accepted at cycle %0d", v.len, v.tms, v.tdi, cyc);
         pulseModelClr();
         @(negedge i_clk);
         i_cmdValid = 1'b0;
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sbQ.size() != 0 && w < 3000) begin
         @(negedge i_clk);
         w++;
      end
      if (sbQ.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending responses, want 0", sbQ.size());
         sbQ.delete();
      end
      @(negedge i_clk);
   endtask

   cmdVecT vecs [9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cmdVecT v;
      int acc;
      int base;
      int accB;
      int seen;
      int w;

      // Loopback expectation: bit k = tdi[k-1], bit 0 = 0, bits >= len = 0.
      vecs[0] = '{6'd5,  32'h0000_0000, 32'h0000_0016, 32'h0000_000C, 41,  5};
      vecs[1] = '{6'd6,  32'h0000_001F, 32'h0000_0000, 32'h0000_0000, 49,  6};
      vecs[2] = '{6'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1,   0};
      vecs[3] = '{6'd40, 32'h0000_0000, 32'hA5A5_A5A5, 32'h4B4B_4B4A, 257, 32};
      vecs[4] = '{6'd1,  32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 9,   1};
      vecs[5] = '{6'd3,  32'h0000_0005, 32'h0000_0007, 32'h0000_0006, 25,  3};
      vecs[6] = '{6'd32, 32'h0000_0000, 32'h8000_0001, 32'h0000_0002, 257, 32};
      vecs[7] = '{6'd8,  32'h0000_00AA, 32'h0000_00FF, 32'h0000_00FE, 65,  8};
      vecs[8] = '{6'd4,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_000E, 33,  4};

      i_rst    = 1'b1;
      tdoForce = 1'b1;
      repeat (2) @(negedge i_clk);
      check("reset_tck", o_TCK, 0);
      check("reset_tms", o_TMS, 1);
      check("reset_tdi", o_TDI, 0);
      check("reset_ready", o_cmdReady, 1);
      check("reset_rspvalid", o_rspValid, 0);
      check("reset_rsptdo", o_rspTdo, 0);
      i_rst    = 1'b0;
      tdoForce = 1'b0;
      pulseModelClr();
      @(negedge i_clk);

      for (int i = 0; i < 9; i++) begin
         sendCmd(vecs[i], acc, base);
         drain();
         if (i == 1) begin
            for (int k = 0; k < 6; k++) begin
               check($sformatf("tms_walk_rise%0d", k + 1), tmsAtRise[(base + k) % 1024],
                     (k < 5) ? 1 : 0);
            end
            repeat (3) @(negedge i_clk);
            check("tms_idle_hold", o_TMS, 0);
         end
      end

      // Reset during the high phase of bit 3 aborts the command.
      v = '{6'd8, 32'h0000_0000, 32'h0000_00FF, 32'h0000_0000, 0, 0};
      sendCmd(v, acc, base);
      w = 0;
      while (riseCnt < base + 4 && w < 1000) begin
         @(negedge i_clk);
         w++;
      end
      check("midrst_reach_bit3", o_TCK, 1);
      seen  = rspSeen;
      i_rst = 1'b1;
      @(negedge i_clk);
      check("midrst_tck", o_TCK, 0);
      check("midrst_ready", o_cmdReady, 1);
      check("midrst_rspvalid", o_rspValid, 0);
      check("midrst_rsptdo", o_rspTdo, 0);
      i_rst = 1'b0;
      sbQ.delete();
      repeat (300) @(negedge i_clk);
      check("midrst_no_rsp", rspSeen - seen, 0);
      v = '{6'd1, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 9, 1};
      sendCmd(v, acc, base);
      drain();

      // Busy: second command held valid through the first shift.
      rspCycHist.delete();
      v = '{6'd3, 32'h0000_0000, 32'h0000_0005, 32'h0000_0002, 25, 3};
      sendCmd(v, acc, base);
      v = '{6'd2, 32'h0000_0003, 32'h0000_0003, 32'h0000_0002, 17, 2};
      sendCmd(v, accB, base);
      drain();
      check("busy_accept_after_rsp", accB, (rspCycHist.size() > 0) ? rspCycHist[0] + 1 : -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jtag_host.md
Name: jtag_host

Overview:
- Initiator side of the RISCII JTAG(esque) debug port. Drives TCK/TMS/TDI into the uP's JTAG pins and captures TDO.
- Converts one command word (bit count, TMS vector, TDI vector) into a bit-serial TCK sequence and returns the captured TDO vector.
- Sits in the debug/bring-up FPGA image (or bench harness) between a host-side controller and the uP JTAG pins.
- TCK is generated from i_clk well below the target's 2-flop-synchronized sampling rate.

Parameters:
- CLK_DIV, 4: i_clk cycles per TCK half-period. Legal range is 4 and above, which guarantees the target's synchronizers see every level.
- MAX_LEN, 32: maximum bits per command; also the vector width.
- LEN_W, 6: width of i_cmdLen.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_cmdValid  in  1  command present
- o_cmdReady  out  1  block idle and able to accept a command
- i_cmdLen  in  LEN_W  number of TCK cycles to run
- i_cmdTms  in  MAX_LEN  TMS value per bit; bit 0 is driven first
- i_cmdTdi  in  MAX_LEN  TDI value per bit; bit 0 is driven first
- o_rspValid  out  1  one-cycle pulse; o_rspTdo is valid during it
- o_rspTdo  out  MAX_LEN  captured TDO; bit k is the value from the k-th TCK cycle
- o_TCK  out  1  JTAG clock; idles low
- o_TMS  out  1  JTAG mode select
- o_TDI  out  1  JTAG data to target
- i_TDO  in  1  JTAG data from target (asynchronous)

Behaviour:
- Reset (i_rst high at a rising edge of i_clk):
  - state=IDLE, o_TCK=0, o_TMS=1, o_TDI=0.
  - o_cmdReady=1, o_rspValid=0, o_rspTdo=0.
  - All counters clear; the synchronizer flops clear.
  - Reset mid-shift aborts the command: no response, TCK low on the following cycle.
- i_TDO passes through a 2-flop synchronizer (tdoS) before any use.
- Command acceptance:
  - A command is accepted on a cycle with i_cmdValid & o_cmdReady.
  - TMS/TDI/len are latched into shift registers at acceptance.
  - o_cmdReady drops on the next cycle.
- Length rules:
  - len=0: go directly to DONE. No TCK edge; response is 0.
  - len>MAX_LEN: saturate to MAX_LEN.
- States:
  - IDLE: TCK low; TMS/TDI hold their last values. On accept: go to LOW (or DONE if len=0); bitIdx=0; divCnt=0.
  - LOW: TCK=0; o_TMS=tms[bitIdx], o_TDI=tdi[bitIdx], both valid from the first LOW cycle. After CLK_DIV cycles go to HIGH.
  - HIGH: TCK=1; TMS/TDI stable. On the last (CLK_DIV-th) HIGH cycle, capture tdoS into tdoReg[bitIdx]. Then:
    - if bitIdx==len-1, go to DONE;
    - otherwise bitIdx++ and go to LOW.
  - DONE: TCK=0; o_rspValid=1 for exactly one cycle; o_rspTdo=tdoReg, with bits at index len and above equal to 0. Go to IDLE with o_cmdReady=1 on the next cycle.
- Timing:
  - Accept-to-o_rspValid latency = 2*CLK_DIV*len + 1 cycles.
  - A new command may be accepted in the cycle after o_rspValid.
- o_rspTdo holds its value until the next DONE or reset.
- i_cmdValid while busy is ignored: no queuing, no effect.
- TMS/TDI change only while TCK is low, never within CLK_DIV cycles of a TCK rising edge.

Decomposition:
- Package jtag_host_pkg:
  - state enum {IDLE, LOW, HIGH, DONE};
  - MAX_LEN and LEN_W defaults;
  - a function for divider terminal count.
- Sub-module jtag_host_synch: 2-flop synchronizer for i_TDO with synchronous active-high clear.
- Everything else (FSM, divider counter, bit counter, shift registers) stays in jtag_host.

Test Plan:
1. Reset: assert i_rst for 2 cycles with i_TDO=1 -> TCK=0, TMS=1, TDI=0, o_cmdReady=1, o_rspValid=0, o_rspTdo=0.
2. Loopback (TDO model = TDI delayed by one TCK rise), CLK_DIV=4, len=5, tdi=0x16, tms=0:
   - exactly 5 TCK rising edges;
   - o_rspValid at accept+41 cycles;
   - o_rspTdo equals the model's shifted pattern, upper bits 0.
3. TMS walk, len=6, tms=0x1F, tdi=0: TMS sampled high at rises 1-5 and low at rise 6; TMS stays 0 in IDLE afterwards.
4. Length bounds:
   - len=0 -> o_rspValid at accept+1, o_rspTdo=0, no TCK edge;
   - len=40 -> exactly 32 TCK rises, latency 257.
5. Reset mid-shift: assert i_rst during HIGH of bit 3 -> TCK=0 next cycle, o_cmdReady=1, no o_rspValid ever. A following len=1 command completes normally.
6. Busy: hold i_cmdValid with a different command throughout a len=3 shift -> first command only until DONE; second accepted the cycle after o_rspValid; both responses correct.
